// File: rtl/line_clear_engine.sv
// rtl/line_clear_engine.sv - removes full playfield rows and reports how many were cleared
//
// Ports:
//   clk, reset_n         clock, asynchronous active-low reset
//   go                   one-cycle start request, sampled only when idle
//   busy, done           pass in progress / one-cycle end-of-pass pulse
//   lines_cleared        full rows removed by the last pass, saturating at 7
//   mem_start            row transfer start strobe (with mem_addr, mem_write_enable)
//   mem_write_enable     transfer direction, qualified by mem_start
//   mem_cont             one cell per cycle for COLS cycles after mem_start
//   mem_addr, mem_wdata  row address / write data towards Memory
//   mem_rdata            combinational read data for the current row and column
module line_clear_engine #(
    parameter int ROWS   = 20,
    parameter int COLS   = 10,
    parameter int CELL_W = 3,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              go,
    output logic              busy,
    output logic              done,
    output logic [2:0]        lines_cleared,
    output logic              mem_start,
    output logic              mem_write_enable,
    output logic              mem_cont,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [CELL_W-1:0] mem_wdata,
    input  logic [CELL_W-1:0] mem_rdata
);

    localparam int                PH_W    = $clog2(COLS + 1);
    localparam logic [PH_W-1:0]   LAST_PH = PH_W'(COLS);
    localparam logic [ADDR_W-1:0] BOTTOM  = ADDR_W'(ROWS - 1);

    // SHIFT is split into its read half (row dst-1 into the buffer) and its
    // write half (buffer into row dst).
    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_SHIFT_RD,
        S_SHIFT_WR,
        S_CLEAR_TOP,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    // phase 0 is the start cycle of a row transfer, phases 1..COLS move one cell each
    logic [PH_W-1:0]   phase;
    logic [PH_W-1:0]   col;
    logic [ADDR_W-1:0] scan_row;
    logic [ADDR_W-1:0] dst;
    logic [CELL_W-1:0] line_buf [COLS];
    logic              full;

    logic              xfer;
    logic              wr;
    logic              last;
    logic              row_full;
    logic [ADDR_W-1:0] row_addr;

    assign col  = phase - 1'b1;
    assign last = (phase == LAST_PH);
    // Folds in the final column, which is only on mem_rdata during the last cycle.
    assign row_full = full & (mem_rdata != '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        xfer      = 1'b0;
        wr        = 1'b0;
        row_addr  = '0;
        case (state)
            S_IDLE: begin
                if (go) begin
                    state_nxt = S_SCAN;
                end
            end
            S_SCAN: begin
                xfer     = 1'b1;
                row_addr = scan_row;
                if (last) begin
                    if (row_full) begin
                        // a full row 0 has nothing above it to shift down
                        state_nxt = (scan_row == '0) ? S_CLEAR_TOP : S_SHIFT_RD;
                    end else begin
                        state_nxt = (scan_row == '0) ? S_DONE : S_SCAN;
                    end
                end
            end
            S_SHIFT_RD: begin
                xfer     = 1'b1;
                row_addr = dst - 1'b1;
                if (last) begin
                    state_nxt = S_SHIFT_WR;
                end
            end
            S_SHIFT_WR: begin
                xfer     = 1'b1;
                wr       = 1'b1;
                row_addr = dst;
                if (last) begin
                    state_nxt = (dst == ADDR_W'(1)) ? S_CLEAR_TOP : S_SHIFT_RD;
                end
            end
            S_CLEAR_TOP: begin
                xfer     = 1'b1;
                wr       = 1'b1;
                row_addr = '0;
                if (last) begin
                    // scan_row is kept so the row that moved into it is rescanned
                    state_nxt = S_SCAN;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        busy             = (state != S_IDLE);
        done             = (state == S_DONE);
        mem_start        = xfer && (phase == '0);
        mem_cont         = xfer && (phase != '0);
        mem_write_enable = mem_start && wr;
        mem_addr         = mem_start ? row_addr : '0;
        // CLEAR_TOP writes zeros, so only the shift write sources the buffer
        mem_wdata        = ((state == S_SHIFT_WR) && mem_cont) ? line_buf[col] : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase         <= '0;
            scan_row      <= '0;
            dst           <= '0;
            lines_cleared <= '0;
            full          <= 1'b0;
        end else begin
            phase <= (xfer && !last) ? phase + 1'b1 : '0;

            if ((state == S_IDLE) && go) begin
                lines_cleared <= '0;
                scan_row      <= BOTTOM;
            end

            if (state == S_SCAN) begin
                full <= mem_start ? 1'b1 : row_full;
                if (last) begin
                    if (row_full) begin
                        if (lines_cleared != 3'd7) begin
                            lines_cleared <= lines_cleared + 1'b1;
                        end
                        dst <= scan_row;
                    end else if (scan_row != '0) begin
                        scan_row <= scan_row - 1'b1;
                    end
                end
            end

            if ((state == S_SHIFT_WR) && last) begin
                dst <= dst - 1'b1;
            end
        end
    end

    // Line buffer contents are don't-care after reset, so no reset here.
    always_ff @(posedge clk) begin
        if (((state == S_SCAN) || (state == S_SHIFT_RD)) && mem_cont) begin
            line_buf[col] <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_line_clear_engine.sv
// tb/tb_line_clear_engine.sv - self-checking bench for line_clear_engine
module tb_line_clear_engine;

    localparam int ROWS = 20;
    localparam int COLS = 10;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       go = 1'b0;
    logic       busy;
    logic       done;
    logic [2:0] lines_cleared;
    logic       mem_start;
    logic       mem_write_enable;
    logic       mem_cont;
    logic [5:0] mem_addr;
    logic [2:0] mem_wdata;
    logic [2:0] mem_rdata;

    line_clear_engine #(
        .ROWS(ROWS), .COLS(COLS), .CELL_W(3), .ADDR_W(6)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .go(go),
        .busy(busy),
        .done(done),
        .lines_cleared(lines_cleared),
        .mem_start(mem_start),
        .mem_write_enable(mem_write_enable),
        .mem_cont(mem_cont),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Playfield memory model
    logic [2:0] board [ROWS][COLS];
    int         m_row = 0;
    int         m_col = 0;
    logic       m_we = 1'b0;
    int         log_q[$];
    int         wd_bad = 0;

    assign mem_rdata = (m_row < ROWS && m_col < COLS) ? board[m_row][m_col] : 3'd0;

    always @(posedge clk) begin
        if (mem_start) begin
            m_row <= int'(mem_addr);
            m_col <= 0;
            m_we  <= mem_write_enable;
        end else if (mem_cont) begin
            m_col <= m_col + 1;
        end
    end

    always @(negedge clk) begin
        if (mem_start) log_q.push_back(mem_write_enable ? 64 + int'(mem_addr) : int'(mem_addr));
        if (mem_cont && m_we && m_row < ROWS && m_col < COLS) board[m_row][m_col] = mem_wdata;
        if (mem_wdata != 3'd0 && !(mem_cont && m_we)) wd_bad++;
    end

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: works on whole rows of a snapshot taken at go
    logic [2:0] snap      [ROWS][COLS];
    logic [2:0] work      [ROWS][COLS];
    logic [2:0] exp_board [ROWS][COLS];
    int         exp_ops[$];
    int         exp_lines;
    int         exp_busy;

    function automatic bit snap_full(input int r);
        for (int c = 0; c < COLS; c++) if (snap[r][c] == 3'd0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit work_full(input int r);
        for (int c = 0; c < COLS; c++) if (work[r][c] == 3'd0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic build_model();
        int d_r;
        int cnt;
        int scan;
        // final board: surviving rows keep their order and settle at the bottom
        d_r = ROWS - 1;
        cnt = 0;
        for (int r = ROWS - 1; r >= 0; r--) begin
            if (snap_full(r)) cnt++;
            else begin
                for (int c = 0; c < COLS; c++) exp_board[d_r][c] = snap[r][c];
                d_r--;
            end
        end
        for (int r = d_r; r >= 0; r--)
            for (int c = 0; c < COLS; c++) exp_board[r][c] = 3'd0;
        exp_lines = (cnt > 7) ? 7 : cnt;
        // expected row-transfer sequence (64 + row marks a write)
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) work[r][c] = snap[r][c];
        exp_ops.delete();
        scan = ROWS - 1;
        while (1) begin
            exp_ops.push_back(scan);
            if (work_full(scan)) begin
                for (int d = scan; d > 0; d--) begin
                    exp_ops.push_back(d - 1);
                    exp_ops.push_back(64 + d);
                    for (int c = 0; c < COLS; c++) work[d][c] = work[d-1][c];
                end
                exp_ops.push_back(64);
                for (int c = 0; c < COLS; c++) work[0][c] = 3'd0;
            end else if (scan == 0) begin
                break;
            end else begin
                scan--;
            end
        end
        exp_busy = 11 * exp_ops.size() + 1;
    endtask

    task automatic clear_board();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) board[r][c] = 3'd0;
    endtask

    task automatic fill_row(input int r, input int fill);
        for (int c = 0; c < COLS; c++)
            board[r][c] = (fill == 0) ? 3'(((r + c) % 7) + 1) : 3'(fill);
    endtask

    task automatic do_pass(output int busy_n, output int done_n, output int done_last, output int first_lines);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) snap[r][c] = board[r][c];
        build_model();
        log_q.delete();
        wd_bad = 0;
        @(negedge clk);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        busy_n = 0;
        done_n = 0;
        done_last = 0;
        first_lines = -1;
        for (int k = 0; k < 12000; k++) begin
            if (!busy) break;
            busy_n++;
            if (busy_n == 1) first_lines = int'(lines_cleared);
            if (done) begin
                done_n++;
                done_last = 1;
            end else begin
                done_last = 0;
            end
            @(negedge clk);
        end
    endtask

    task automatic check_pass(input string name, input bit use_tbl, input int tbl_lines, input int tbl_busy);
        int b, dn, dl, fl, bad_idx, bad_cells;
        do_pass(b, dn, dl, fl);
        check({name, " busy_cycles"}, b, use_tbl ? tbl_busy : exp_busy);
        check({name, " lines_cleared"}, int'(lines_cleared), use_tbl ? tbl_lines : exp_lines);
        check({name, " done_pulses"}, dn, 1);
        check({name, " done_on_last_busy"}, dl, 1);
        check({name, " lines_zero_at_accept"}, fl, 0);
        check({name, " xfer_count"}, log_q.size(), exp_ops.size());
        bad_idx = -1;
        for (int i = 0; i < log_q.size() && i < exp_ops.size(); i++)
            if (log_q[i] != exp_ops[i]) begin
                bad_idx = i;
                break;
            end
        check({name, " xfer_first_bad_index"}, bad_idx, -1);
        bad_cells = 0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (board[r][c] != exp_board[r][c]) bad_cells++;
        check({name, " board_bad_cells"}, bad_cells, 0);
        check({name, " wdata_nonzero_when_idle"}, wd_bad, 0);
        repeat (3) @(negedge clk);
        check({name, " lines_held"}, int'(lines_cleared), use_tbl ? tbl_lines : exp_lines);
    endtask

    typedef struct {
        logic [19:0] full_mask;
        int          fill;
        bit          row15_part;
        int          lines;
        int          busy;
    } vec_t;

    vec_t tbl[5];

    function automatic int out_word();
        return int'({busy, done, lines_cleared, mem_start, mem_write_enable, mem_cont, mem_addr, mem_wdata});
    endfunction

    initial begin
        int b, found, idle_busy;
        tbl[0] = '{20'h80000, 3, 1'b0, 1, 661};
        tbl[1] = '{20'h00000, 0, 1'b0, 0, 221};
        tbl[2] = '{20'hF0000, 0, 1'b1, 4, 1981};
        tbl[3] = '{20'h00001, 0, 1'b0, 1, 243};
        tbl[4] = '{20'hFF000, 0, 1'b0, 7, 3741};

        clear_board();
        repeat (3) @(negedge clk);
        check("reset_outputs", out_word(), 0);
        reset_n = 1'b1;
        @(negedge clk);
        check("idle_after_reset", out_word(), 0);

        for (int v = 0; v < 5; v++) begin
            clear_board();
            for (int r = 0; r < ROWS; r++) if (tbl[v].full_mask[r]) fill_row(r, tbl[v].fill);
            if (tbl[v].row15_part)
                for (int c = 0; c < COLS; c++) board[15][c] = (c % 2 == 0) ? 3'((c / 2) % 7 + 1) : 3'd0;
            check_pass($sformatf("tbl%0d", v), 1'b1, tbl[v].lines, tbl[v].busy);
        end

        // go held three cycles plus a re-pulse mid-pass: exactly one pass
        clear_board();
        log_q.delete();
        @(negedge clk);
        go = 1'b1;
        @(negedge clk);
        b = 0;
        for (int k = 0; k < 2000; k++) begin
            if (!busy) break;
            b++;
            go = (b <= 2 || b == 50);
            @(negedge clk);
        end
        go = 1'b0;
        idle_busy = 0;
        repeat (5) begin
            if (busy) idle_busy++;
            @(negedge clk);
        end
        check("held_go busy_cycles", b, 221);
        check("held_go xfer_count", log_q.size(), 20);
        check("held_go not_queued", idle_busy, 0);

        // reset in the middle of a shift
        clear_board();
        fill_row(19, 5);
        @(negedge clk);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        found = 0;
        for (int k = 0; k < 200; k++) begin
            if (mem_start && mem_write_enable) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        check("midshift write_start_seen", found, 1);
        repeat (3) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("midshift async_reset_outputs", out_word(), 0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("midshift idle_after_release", out_word(), 0);
        check_pass("after_reset", 1'b0, 0, 0);

        // randomized boards against the reference model
        for (int v = 0; v < 6; v++) begin
            clear_board();
            for (int r = 0; r < ROWS; r++) begin
                if ($urandom_range(0, 3) == 0)
                    for (int c = 0; c < COLS; c++) board[r][c] = 3'($urandom_range(1, 7));
                else
                    for (int c = 0; c < COLS; c++) board[r][c] = 3'($urandom_range(0, 7));
            end
            check_pass($sformatf("rand%0d", v), 1'b0, 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/line_clear_engine.md
Name: line_clear_engine

Overview:
- Initiator-side master for the playfield Memory port (start / write_enable / cont / addr, 10 cells per row, 3-bit cells, 0 = empty).
- On a go pulse from Game, scans the visible playfield from the bottom row up and removes every full row by shifting all rows above it down one.
- Writes zeros into row 0 after each shift and reports the number of rows cleared.
- Shares the Memory port with Game through an external mux selected by busy.

Parameters:
ROWS, 20, number of visible rows (addresses 0..ROWS-1; bottom row = ROWS-1)
COLS, 10, cells per row
CELL_W, 3, bits per cell
ADDR_W, 6, row address width (matches address_t)

Ports:
clk  in  1  system clock (pixel clock domain)
reset_n  in  1  asynchronous active-low reset
go  in  1  one-cycle request to start a clear pass; ignored while busy
busy  out  1  high from the cycle after go is accepted until the done cycle, inclusive
done  out  1  one-cycle pulse at the end of the pass
lines_cleared  out  3  full rows removed in the last pass; saturates at 7
mem_start  out  1  Memory start strobe
mem_write_enable  out  1  write qualifier, meaningful only with mem_start
mem_cont  out  1  advance / transfer one cell
mem_addr  out  ADDR_W  row address, meaningful only with mem_start
mem_wdata  out  CELL_W  cell data to Memory
mem_rdata  in  CELL_W  combinational Memory read data for the current row/column

Behaviour:
- Reset (async, reset_n=0): state IDLE; busy, done, mem_start, mem_write_enable, mem_cont = 0; mem_addr, mem_wdata, lines_cleared = 0; line buffer contents don't-care. Reset mid-pass aborts immediately; Memory contents are left as they are.
- Row transfer (11 cycles):
  - Cycle 0: mem_start=1, mem_addr=row, mem_write_enable = 1 for a write / 0 for a read.
  - Cycles 1..COLS: mem_cont=1, column index i = 0..COLS-1.
  - Read: buf[i] <= mem_rdata at the clock edge ending cycle i+1.
  - Write: mem_wdata = buf[i] during cycle i+1.
  - mem_wdata = 0 whenever not writing. Outside a transfer all strobes are 0.
- Line buffer: COLS x CELL_W registers plus a full flag. The full flag is the AND over all columns of (cell != 0), accumulated during the read.
- States and transitions:
  - IDLE: if go, then lines_cleared <= 0, scan_row <= ROWS-1, go to SCAN.
  - SCAN: read scan_row. If not full: when scan_row == 0 go to DONE, otherwise scan_row-- and SCAN again. If full: lines_cleared++ (saturating), dst <= scan_row, go to SHIFT.
  - SHIFT: when dst == 0 go to CLEAR_TOP. Otherwise read row dst-1 into buf, write buf to row dst, dst--, and repeat SHIFT.
  - CLEAR_TOP: write COLS zeros to row 0 (buf is not used), then go to SCAN with scan_row unchanged, so the row that just shifted down is rescanned.
  - DONE: done=1 for one cycle, then IDLE. lines_cleared holds until the next accepted go.
- busy = (state != IDLE). go is sampled only in IDLE; go while busy has no effect and is not queued.
- The first mem_start occurs in the cycle after go is sampled.
- Boundaries:
  - Full row 0: clear row 0, then rescan it (now empty), then DONE.
  - Consecutive full rows are handled by the rescan; the pass terminates because each clear adds an empty row 0.
  - mem_rdata values 1..7 all count as occupied.

Test Plan:
- Empty board, pulse go -> 20 read transfers on rows 19,18..0 (mem_write_enable=0 on every start); busy high for 221 cycles; done in cycle 221; lines_cleared=0; no write starts.
- Row 19 full (all cells 3), rows 0..18 empty -> lines_cleared=1; 19 shifts (read 18 / write 19 ... read 0 / write 1), then zero-write to row 0, then rescan of 19 and scans of 18..0; busy 661 cycles; final board empty.
- Rows 16..19 full with distinct patterns; row 15 = cells 1,0,2,0,... -> lines_cleared=4; final row 19 equals the old row 15 pattern; rows 0..18 empty.
- Row 0 full only -> shift-free path: row 0 written with zeros, rescanned, done; lines_cleared=1.
- go re-pulsed during busy, plus go held high for 3 cycles -> single pass only; a second go after done starts a new pass and resets lines_cleared to 0 at acceptance.
- reset_n asserted mid-SHIFT -> all outputs 0 in the same cycle, asynchronously; after release, IDLE with busy=0; a following go pass completes normally.
